// File: rtl/cp0_pkg.sv
// Shared CP0 definitions for the interrupt/ERET sequencer: FSM states, register
// addresses, STATUS/CAUSE field positions and the interrupt priority encoder.
package cp0_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        TAKE    = 3'd2,
        HANDLER = 3'd3,
        RETURN  = 3'd4
    } ctrlState_t;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_CAUSE   = 2'd1;
    localparam logic [1:0] ADDR_EPC     = 2'd2;
    localparam logic [1:0] ADDR_COMPARE = 2'd3;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int IM_BASE    = 8;
    localparam int CODE_LSB   = 2;
    localparam int CODE_W     = 5;

    // Lowest set bit wins, so line 0 has the highest priority and the timer slot the lowest.
    function automatic logic [CODE_W-1:0] lowestSet(input logic [15:0] vec);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = i[CODE_W-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser bringing the asynchronous irq lines into the clk domain.
module irq_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] irqRaw,
    output logic [WIDTH-1:0] irqSynced
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], irqRaw};
    end

    assign irqSynced = chain[STAGES-1];

endmodule

// File: rtl/int_eret_ctrl.sv
// Interrupt/ERET sequencer: picks a safe ID-stage boundary, redirects to the vector, returns via EPC.
// Optional CP0 COUNT/COMPARE timer interrupt is built when CP0_TIMER_EN is defined.
module int_eret_ctrl
    import cp0_pkg::*;
#(
    parameter int          N_IRQ       = 6,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0080,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic [31:0]      id_pc,
    input  logic             id_eret,
    input  logic             pipe_stall,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic             int_flush,
    output logic             in_handler
);

    ctrlState_t         state;
    logic [N_IRQ-1:0]   irqSync;
    logic               ie, exl;
    logic [N_IRQ-1:0]   im;
    logic [CODE_W-1:0]  code;
    logic [31:0]        epc;
    logic               timerPend, timerIm;
    logic [31:0]        compareRd;
    logic [N_IRQ:0]     pending;
    logic               req;
    logic [31:0]        statusWord, causeWord;

    irq_sync #(.WIDTH(N_IRQ), .STAGES(SYNC_STAGES)) uSync (
        .clk      (clk),
        .reset    (reset),
        .irqRaw   (irq),
        .irqSynced(irqSync)
    );

`ifdef CP0_TIMER_EN
    logic [31:0] count, compare;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            compare   <= '0;
            timerPend <= 1'b0;
            timerIm   <= 1'b0;
        end else begin
            count <= count + 32'd1;
            if (cfg_we && cfg_addr == ADDR_STATUS) timerIm <= cfg_wdata[IM_BASE+N_IRQ];
            if (cfg_we && cfg_addr == ADDR_COMPARE) begin
                compare   <= cfg_wdata;
                timerPend <= 1'b0;
            end else if (count == compare) begin
                timerPend <= 1'b1;
            end
        end
    end

    assign compareRd = compare;
`else
    assign timerPend = 1'b0;
    assign timerIm   = 1'b0;
    assign compareRd = '0;
`endif

    assign pending = {timerPend, irqSync} & {timerIm, im};
    assign req     = (|pending) && ie && !exl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ie    <= 1'b0;
            exl   <= 1'b0;
            im    <= '0;
            code  <= '0;
            epc   <= '0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_STATUS: begin
                        ie  <= cfg_wdata[STATUS_IE];
                        exl <= cfg_wdata[STATUS_EXL];
                        im  <= cfg_wdata[IM_BASE +: N_IRQ];
                    end
                    ADDR_CAUSE: code <= cfg_wdata[CODE_LSB +: CODE_W];
                    ADDR_EPC:   epc  <= cfg_wdata;
                    default: ;
                endcase
            end
            // NOTE: the FSM assignments below come after the CP0 write, so the last
            // non-blocking assignment wins and TAKE/RETURN override IE/EXL/EPC/code.
            case (state)
                IDLE: if (req) state <= ARM;
                ARM: begin
                    if (!req)                                     state <= IDLE;
                    else if (id_valid && !id_branch && !pipe_stall) state <= TAKE;
                end
                TAKE: begin
                    epc   <= id_pc;
                    exl   <= 1'b1;
                    ie    <= 1'b0;
                    code  <= lowestSet(16'(pending));
                    state <= HANDLER;
                end
                HANDLER: if (id_eret && id_valid && !pipe_stall) state <= RETURN;
                RETURN: begin
                    exl   <= 1'b0;
                    ie    <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        statusWord                        = '0;
        statusWord[STATUS_IE]             = ie;
        statusWord[STATUS_EXL]            = exl;
        statusWord[IM_BASE +: N_IRQ]      = im;
        statusWord[IM_BASE + N_IRQ]       = timerIm;
        causeWord                         = '0;
        causeWord[IM_BASE +: N_IRQ + 1]   = {timerPend, irqSync};
        causeWord[CODE_LSB +: CODE_W]     = code;
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_STATUS:  cfg_rdata = statusWord;
            ADDR_CAUSE:   cfg_rdata = causeWord;
            ADDR_EPC:     cfg_rdata = epc;
            ADDR_COMPARE: cfg_rdata = compareRd;
            default:      cfg_rdata = '0;
        endcase
    end

    assign pc_redirect = (state == TAKE) || (state == RETURN);
    assign int_flush   = pc_redirect;
    assign pc_target   = (state == TAKE)   ? EXC_VECTOR :
                         (state == RETURN) ? epc        : 32'h0;
    assign in_handler  = exl;

endmodule
